iob_clint_core: RTL and testbench
=================================

# iob_clint_core

RISC-V Core-Local Interruptor (CLINT) with an IOb native slave port, using the SiFive-compatible register map. It holds one 64-bit `mtime` counter advanced by an external real-time tick, plus per-hart `mtimecmp` and `msip` registers. It drives the machine timer (`mtip`) and software (`msip`) interrupt lines of up to `N_CORES` harts. It sits on the SoC peripheral bus next to the CPU cores.

## Interface
- `ADDR_W`, 16: IOb byte-address width; must be ≥16.
- `DATA_W`, 32: IOb data width; only 32 is supported.
- `N_CORES`, 1: number of harts, 1..16.
- `clk_i`  in  1  system clock; the only clock.
- `cke_i`  in  1  clock enable; when 0, all state holds.
- `arst_i`  in  1  reset; synchronous and active-high.
- `rt_clk`  in  1  real-time tick; sampled in `clk_i`.
- `iob_avalid`  in  1  request valid.
- `iob_addr`  in  ADDR_W  byte address.
- `iob_wdata`  in  DATA_W  write data.
- `iob_wstrb`  in  DATA_W/8  byte strobes; nonzero = write, zero = read.
- `iob_rvalid`  out  1  read data valid.
- `iob_rdata`  out  DATA_W  read data.
- `iob_ready`  out  1  request accepted.
- `mtip`  out  N_CORES  timer interrupt per hart.
- `msip`  out  N_CORES  software interrupt per hart.

## Operation
- Register map, with byte offsets decoded on `iob_addr[15:2]`; `iob_addr[1:0]` is ignored:
  - `0x0000 + 4*h`: `msip[h]`. Only bit 0 is stored; other bits read 0.
  - `0x4000 + 8*h`: `mtimecmp[h]` low word. `+4`: high word.
  - `0xBFF8`: `mtime` low word. `0xBFFC`: high word.
  - Any other address, including `h ≥ N_CORES`: reads return 0 and writes are ignored.
- Writes honour `iob_wstrb` per byte.
- `mtime`:
  - `rt_clk` passes through a 2-flop synchronizer followed by a rising-edge detector.
  - Each detected edge increments `mtime` by 1, wrapping at 2^64 to 0.
  - If a bus write to `mtime` and an increment occur in the same cycle, the write wins and no increment is applied.
- `mtip[h]` = (`mtime` ≥ `mtimecmp[h]`), an unsigned 64-bit compare, registered.
- `msip[h]` = `msip` register bit 0 of hart h.
- Reset values:
  - `mtime` = 0.
  - `mtimecmp[h]` = all ones.
  - `msip` = 0.
  - Synchronizer flops = 0.
  - `mtip` = 0, `msip` = 0, `iob_rvalid` = 0, `iob_rdata` = 0.

## Timing
- `iob_ready` is constantly 1 when not in reset; every request is accepted in its `avalid` cycle.
- Write: registers update at the clock edge that samples `avalid`.
- Read:
  - `iob_rvalid` pulses high for exactly 1 cycle, one cycle after a read request.
  - `iob_rdata` is registered and valid in that cycle; it holds its last value otherwise.
  - Back-to-back reads are allowed; each returns one `rvalid` cycle later.
- A read returns the register value before any write in the same cycle.
- `rt_clk` latency: a rising edge on `rt_clk` changes `mtime` 3 `clk_i` edges later.
- `rt_clk` must have its high and low phases each ≥2 `clk_i` periods; faster ticks may be lost.
- `mtip` updates 1 cycle after `mtime` or `mtimecmp` changes. `msip` output updates in the cycle after the write edge.
- Reset asserted mid-operation:
  - All state returns to reset values at the next edge.
  - A pending `rvalid` is dropped.
  - An `rt_clk` edge in flight is lost.
- `cke_i` = 0 freezes all registers, including a pending `rvalid`.
- Software reading 64-bit `mtime` must use the hi/lo/hi retry sequence; the block provides no atomic latch.

## Structure
- Shared package `iob_clint_pkg` holds:
  - `MSIP_BASE` = 0x0000, `MTIMECMP_BASE` = 0x4000, `MTIME_BASE` = 0xBFF8.
  - `MTIME_W` = 64.
  - `MTIMECMP_RST` = all ones.
- Sub-module `iob_clint_rtc_sync`: 2-flop synchronizer plus rising-edge detector; outputs a 1-cycle `tick` pulse.
- The top level contains the address decoder, register file, comparators and read mux.

## Test plan
- Reset: after `arst_i` is released, `mtip` = 0 and `msip` = 0. Reads return `mtime` = 0 and `mtimecmp[0]` = 0xFFFFFFFF/0xFFFFFFFF. `iob_ready` = 1.
- `msip`: write 1 to 0x0000 → `msip[0]` = 1 on the next cycle, and a read returns 1. Write 0 → `msip[0]` clears. Write 0xFFFFFFFF → a read returns 0x00000001.
- Timer: write `mtimecmp[0]` = 10 (high word 0, then low word 10), toggle `rt_clk` 10 times → `mtip[0]` rises after the 10th tick. Rewriting `mtimecmp[0]` = 20 → `mtip[0]` drops 1 cycle later.
- Carry and wrap: write `mtime` = 0x00000000_FFFFFFFF, apply 1 tick → reads return low = 0, high = 1. Write 0xFFFFFFFF_FFFFFFFF, apply 1 tick → reads return 0.
- Strobes and unmapped addresses: write 0xAABBCCDD with `wstrb` = 0b0010 to `mtimecmp[0]` low word → a read returns 0xFFFFCCFF. A read of 0x8000 → `rvalid` after 1 cycle with data 0.
- Collision: a bus write of `mtime` = 5 in the same cycle as a tick → a read returns 5.

Source files
------------

// File: rtl/iob_clint_pkg.sv
// -----------------------------------------------------------------------------
// iob_clint_pkg
// Shared definitions for the IOb CLINT:
//   - SiFive-compatible register map bases
//   - mtime width and mtimecmp reset value
//   - register-select type produced by the address decoder
//   - helpers for address decode and byte-strobe merging
// No ports (package).
// -----------------------------------------------------------------------------
package iob_clint_pkg;

    localparam int unsigned MSIP_BASE     = 32'h0000_0000;
    localparam int unsigned MTIMECMP_BASE = 32'h0000_4000;
    localparam int unsigned MTIME_BASE    = 32'h0000_BFF8;

    localparam int unsigned MTIME_W = 64;
    localparam logic [MTIME_W-1:0] MTIMECMP_RST = '1;

    // Register word width seen on the bus; the block only supports 32.
    localparam int unsigned REG_W  = 32;
    localparam int unsigned STRB_W = REG_W / 8;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_MSIP,
        REG_MTIMECMP_LO,
        REG_MTIMECMP_HI,
        REG_MTIME_LO,
        REG_MTIME_HI
    } reg_sel_e;

    typedef struct packed {
        reg_sel_e   sel;
        logic [3:0] hart;
    } reg_dec_t;

    // Decodes the 16-bit byte offset. Byte lanes [1:0] are ignored, and any
    // per-hart slot at or beyond n_cores decodes to REG_NONE so that it reads
    // 0 and swallows writes.
    function automatic reg_dec_t decode_addr(input logic [15:0] addr,
                                             input int unsigned n_cores);
        reg_dec_t    d;
        logic [15:0] off;
        int unsigned off_i;
        off    = {addr[15:2], 2'b00};
        off_i  = {16'd0, off};
        d.sel  = REG_NONE;
        d.hart = '0;
        if (off_i < MSIP_BASE + 4 * n_cores) begin
            d.sel  = REG_MSIP;
            d.hart = off[5:2];
        end else if (off_i >= MTIMECMP_BASE &&
                     off_i <  MTIMECMP_BASE + 8 * n_cores) begin
            d.sel  = off[2] ? REG_MTIMECMP_HI : REG_MTIMECMP_LO;
            d.hart = off[6:3];
        end else if (off_i == MTIME_BASE) begin
            d.sel = REG_MTIME_LO;
        end else if (off_i == MTIME_BASE + 4) begin
            d.sel = REG_MTIME_HI;
        end
        return d;
    endfunction

    // Merges new_v into old_v on the byte lanes selected by strb.
    function automatic logic [REG_W-1:0] apply_wstrb(input logic [REG_W-1:0]  old_v,
                                                     input logic [REG_W-1:0]  new_v,
                                                     input logic [STRB_W-1:0] strb);
        logic [REG_W-1:0] r;
        for (int b = 0; b < int'(STRB_W); b++) begin
            r[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/iob_clint_if.sv
// -----------------------------------------------------------------------------
// iob_clint_if
// IOb native bus bundle between a bus master and the CLINT.
//   iob_avalid  master->slave  request valid
//   iob_addr    master->slave  byte address
//   iob_wdata   master->slave  write data
//   iob_wstrb   master->slave  byte strobes (nonzero = write, zero = read)
//   iob_rvalid  slave->master  read data valid (1-cycle pulse)
//   iob_rdata   slave->master  read data
//   iob_ready   slave->master  request accepted
// -----------------------------------------------------------------------------
interface iob_clint_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              iob_avalid;
    logic [ADDR_W-1:0] iob_addr;
    logic [DATA_W-1:0] iob_wdata;
    logic [DATA_W/8-1:0] iob_wstrb;
    logic              iob_rvalid;
    logic [DATA_W-1:0] iob_rdata;
    logic              iob_ready;

    modport master (
        output iob_avalid, iob_addr, iob_wdata, iob_wstrb,
        input  iob_rvalid, iob_rdata, iob_ready
    );

    modport slave (
        input  iob_avalid, iob_addr, iob_wdata, iob_wstrb,
        output iob_rvalid, iob_rdata, iob_ready
    );
endinterface

// File: rtl/iob_clint_rtc_sync.sv
// -----------------------------------------------------------------------------
// iob_clint_rtc_sync
// Brings the asynchronous real-time tick into the clk_i domain through a
// 2-flop synchronizer, then emits a 1-cycle pulse per rising edge.
//   clk_i   in   system clock
//   cke_i   in   clock enable; all flops hold when 0
//   arst_i  in   synchronous active-high reset
//   rt_clk  in   asynchronous real-time tick
//   tick    out  1-cycle pulse per detected rt_clk rising edge
// A rising edge on rt_clk raises tick after the second clk_i edge, so the
// counter that consumes it changes on the third edge.
// -----------------------------------------------------------------------------
module iob_clint_rtc_sync (
    input  logic clk_i,
    input  logic cke_i,
    input  logic arst_i,
    input  logic rt_clk,
    output logic tick
);
    logic [1:0] sync_q;   // [0] may go metastable, [1] is the settled copy
    logic       prev_q;   // settled level one cycle earlier, for edge detect

    // NOTE: every flop is written with <= so all of them sample the values
    // from before the edge; with = the chain would collapse into one stage.
    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else if (cke_i) begin
            sync_q <= {sync_q[0], rt_clk};
            prev_q <= sync_q[1];
        end
    end

    assign tick = sync_q[1] & ~prev_q;
endmodule

// File: rtl/iob_clint_core.sv
// -----------------------------------------------------------------------------
// iob_clint_core
// RISC-V Core-Local Interruptor with an IOb native slave port and the
// SiFive-compatible register map: one 64-bit mtime counter advanced by an
// external real-time tick, plus per-hart mtimecmp and msip registers.
//   clk_i    in   system clock
//   cke_i    in   clock enable; all state holds when 0
//   arst_i   in   synchronous active-high reset
//   rt_clk   in   real-time tick (asynchronous, slow)
//   bus      slave modport of iob_clint_if (IOb request/response)
//   mtip     out  per-hart machine timer interrupt (registered compare)
//   msip     out  per-hart machine software interrupt
// Contains the address decoder, register file, comparators and read mux.
// -----------------------------------------------------------------------------
module iob_clint_core
    import iob_clint_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int N_CORES = 1
) (
    input  logic               clk_i,
    input  logic               cke_i,
    input  logic               arst_i,
    input  logic               rt_clk,
    iob_clint_if.slave         bus,
    output logic [N_CORES-1:0] mtip,
    output logic [N_CORES-1:0] msip
);
    localparam logic [MTIME_W-1:0] MTIME_ONE = {{(MTIME_W-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wr_en;
    logic                rd_en;
    reg_dec_t            dec;

    assign addr  = bus.iob_addr;
    assign wdata = bus.iob_wdata;
    assign wstrb = bus.iob_wstrb;
    assign wr_en = bus.iob_avalid &  (|wstrb);
    assign rd_en = bus.iob_avalid & ~(|wstrb);
    assign dec   = decode_addr(addr[15:0], N_CORES);

    // ------------------------------------------------------------------
    // Real-time tick
    // ------------------------------------------------------------------
    logic tick;

    iob_clint_rtc_sync u_rtc_sync (
        .clk_i  (clk_i),
        .cke_i  (cke_i),
        .arst_i (arst_i),
        .rt_clk (rt_clk),
        .tick   (tick)
    );

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [MTIME_W-1:0] mtime_q;
    logic [MTIME_W-1:0] mtimecmp_q [N_CORES];
    logic [N_CORES-1:0] msip_q;
    logic [N_CORES-1:0] mtip_q;
    logic               rvalid_q;
    logic [DATA_W-1:0]  rdata_q;
    logic [DATA_W-1:0]  rd_mux;

    // NOTE: mtimecmp is a small per-hart flop array, not a RAM, so it is
    // reset in a loop; its all-ones value keeps mtip quiet until software
    // programs a deadline.
    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            mtime_q  <= '0;
            for (int h = 0; h < N_CORES; h++) begin
                mtimecmp_q[h] <= MTIMECMP_RST;
            end
            msip_q   <= '0;
            mtip_q   <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else if (cke_i) begin
            // Reads see the pre-write contents because rd_mux samples the
            // flops before this edge updates them.
            rvalid_q <= rd_en;
            if (rd_en) begin
                rdata_q <= rd_mux;
            end

            // A bus write to either half of mtime takes priority over the
            // tick, and the tick is discarded rather than deferred.
            if (wr_en && dec.sel == REG_MTIME_LO) begin
                mtime_q[31:0] <= apply_wstrb(mtime_q[31:0], wdata, wstrb);
            end else if (wr_en && dec.sel == REG_MTIME_HI) begin
                mtime_q[63:32] <= apply_wstrb(mtime_q[63:32], wdata, wstrb);
            end else if (tick) begin
                mtime_q <= mtime_q + MTIME_ONE;
            end

            for (int h = 0; h < N_CORES; h++) begin
                if (wr_en && dec.hart == 4'(h)) begin
                    case (dec.sel)
                        REG_MSIP: begin
                            if (wstrb[0]) begin
                                msip_q[h] <= wdata[0];
                            end
                        end
                        REG_MTIMECMP_LO: begin
                            mtimecmp_q[h][31:0] <=
                                apply_wstrb(mtimecmp_q[h][31:0], wdata, wstrb);
                        end
                        REG_MTIMECMP_HI: begin
                            mtimecmp_q[h][63:32] <=
                                apply_wstrb(mtimecmp_q[h][63:32], wdata, wstrb);
                        end
                        default: ;
                    endcase
                end
                // Registered compare: follows mtime/mtimecmp by one cycle.
                mtip_q[h] <= (mtime_q >= mtimecmp_q[h]);
            end
        end
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    // NOTE: rd_mux gets a default before the case so every path assigns it
    // and no latch is inferred for unmapped selections.
    always_comb begin
        rd_mux = '0;
        case (dec.sel)
            REG_MTIME_LO: rd_mux = mtime_q[31:0];
            REG_MTIME_HI: rd_mux = mtime_q[63:32];
            default: begin
                for (int h = 0; h < N_CORES; h++) begin
                    if (dec.hart == 4'(h)) begin
                        if (dec.sel == REG_MSIP) begin
                            rd_mux = {{(DATA_W-1){1'b0}}, msip_q[h]};
                        end else if (dec.sel == REG_MTIMECMP_LO) begin
                            rd_mux = mtimecmp_q[h][31:0];
                        end else if (dec.sel == REG_MTIMECMP_HI) begin
                            rd_mux = mtimecmp_q[h][63:32];
                        end
                    end
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.iob_ready  = ~arst_i;
    assign bus.iob_rvalid = rvalid_q;
    assign bus.iob_rdata  = rdata_q;
    assign mtip           = mtip_q;
    assign msip           = msip_q;
endmodule

// File: tb/tb_iob_clint_core.sv
// -----------------------------------------------------------------------------
// tb_iob_clint_core
// Self-checking bench for iob_clint_core with one hart. A behavioural model
// keeps mtime, mtimecmp[0] and msip[0] as plain variables updated from the
// register map rules; DUT reads and interrupt lines are compared against it.
// Inputs change on the falling clock edge, outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_iob_clint_core;

    logic       clk_i = 1'b0;
    logic       cke_i;
    logic       arst_i;
    logic       rt_clk;
    logic [0:0] mtip;
    logic [0:0] msip;

    iob_clint_if #(.ADDR_W(16), .DATA_W(32)) bus ();

    iob_clint_core #(.ADDR_W(16), .DATA_W(32), .N_CORES(1)) dut (
        .clk_i  (clk_i),
        .cke_i  (cke_i),
        .arst_i (arst_i),
        .rt_clk (rt_clk),
        .bus    (bus),
        .mtip   (mtip),
        .msip   (msip)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    logic [63:0] m_mtime;
    logic [63:0] m_cmp;
    logic        m_msip;

    // ---------------- model ----------------
    function automatic logic [31:0] merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  s);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = new_v[8*b +: 8];
        return r;
    endfunction

    task automatic model_reset();
        m_mtime = 64'd0;
        m_cmp   = {64{1'b1}};
        m_msip  = 1'b0;
    endtask

    task automatic model_write(input logic [15:0] a, input logic [31:0] d,
                               input logic [3:0] s);
        case ({a[15:2], 2'b00})
            16'h0000: if (s[0]) m_msip = d[0];
            16'h4000: m_cmp[31:0]    = merge(m_cmp[31:0], d, s);
            16'h4004: m_cmp[63:32]   = merge(m_cmp[63:32], d, s);
            16'hBFF8: m_mtime[31:0]  = merge(m_mtime[31:0], d, s);
            16'hBFFC: m_mtime[63:32] = merge(m_mtime[63:32], d, s);
            default: ;
        endcase
    endtask

    // ---------------- bus helpers ----------------
    task automatic bus_write(input logic [15:0] a, input logic [31:0] d,
                             input logic [3:0] s);
        @(negedge clk_i);
        bus.iob_avalid = 1'b1;
        bus.iob_addr   = a;
        bus.iob_wdata  = d;
        bus.iob_wstrb  = s;
        @(negedge clk_i);
        bus.iob_avalid = 1'b0;
        bus.iob_wstrb  = 4'h0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d,
                      input logic [3:0] s);
        bus_write(a, d, s);
        model_write(a, d, s);
    endtask

    task automatic rd(input logic [15:0] a, output logic [31:0] d,
                      output logic rv);
        @(negedge clk_i);
        bus.iob_avalid = 1'b1;
        bus.iob_addr   = a;
        bus.iob_wstrb  = 4'h0;
        @(negedge clk_i);
        bus.iob_avalid = 1'b0;
        rv = bus.iob_rvalid;
        d  = bus.iob_rdata;
    endtask

    task automatic rd64(input logic [15:0] a, output logic [63:0] d,
                        output logic rv);
        logic [31:0] lo, hi;
        logic        rv_lo, rv_hi;
        rd(a, lo, rv_lo);
        rd(a + 16'd4, hi, rv_hi);
        d  = {hi, lo};
        rv = rv_lo & rv_hi;
    endtask

    // One slow rt_clk period: high 2 cycles, low 2 cycles. mtime moves on
    // the third clock edge after the rise, mtip one edge after that.
    task automatic tick();
        @(negedge clk_i);
        rt_clk = 1'b1;
        repeat (2) @(negedge clk_i);
        rt_clk = 1'b0;
        repeat (2) @(negedge clk_i);
        m_mtime = m_mtime + 64'd1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [63:0] d64;
        logic        rv;
        arst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        arst_i = 1'b0;
        model_reset();
        @(negedge clk_i);
        checks++;
        if (mtip !== 1'b0 || msip !== 1'b0 || bus.iob_ready !== 1'b1 || bus.iob_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: mtip=%b msip=%b ready=%b rvalid=%b, want 0 0 1 0",
                     mtip, msip, bus.iob_ready, bus.iob_rvalid);
        end
        rd64(16'hBFF8, d64, rv);
        checks++;
        if (rv !== 1'b1 || d64 !== 64'd0) begin
            failures++;
            $display("FAIL reset_mtime: rvalid=%b data=%h, want 1 %h", rv, d64, 64'd0);
        end
        rd64(16'h4000, d64, rv);
        checks++;
        if (rv !== 1'b1 || d64 !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            failures++;
            $display("FAIL reset_mtimecmp: rvalid=%b data=%h, want 1 ffffffffffffffff", rv, d64);
        end
    endtask

    task automatic test_strobes_unmapped();
        logic [31:0] d;
        logic [63:0] d64;
        logic        rv;
        logic [15:0] regs [4] = '{16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC};
        logic [15:0] bad  [6] = '{16'h8000, 16'h0004, 16'h4008, 16'h400C, 16'hBFF0, 16'h1234};
        logic [15:0] a;
        logic [31:0] wd;
        wr(16'h4000, 32'hAABB_CCDD, 4'b0010);
        rd(16'h4000, d, rv);
        checks++;
        if (rv !== 1'b1 || d !== 32'hFFFF_CCFF) begin
            failures++;
            $display("FAIL strobe_fixed: rvalid=%b data=%h, want 1 ffffccff", rv, d);
        end
        for (int i = 0; i < 8; i++) begin
            a  = regs[$urandom_range(0, 3)] | 16'($urandom_range(0, 3));
            wd = $urandom;
            wr(a, wd, 4'($urandom_range(1, 15)));
        end
        rd64(16'h4000, d64, rv);
        checks++;
        if (rv !== 1'b1 || d64 !== m_cmp) begin
            failures++;
            $display("FAIL strobe_rand_cmp: rvalid=%b data=%h, want 1 %h", rv, d64, m_cmp);
        end
        rd64(16'hBFF8, d64, rv);
        checks++;
        if (rv !== 1'b1 || d64 !== m_mtime) begin
            failures++;
            $display("FAIL strobe_rand_mtime: rvalid=%b data=%h, want 1 %h", rv, d64, m_mtime);
        end
        for (int i = 0; i < 6; i++) begin
            wr(bad[i], $urandom, 4'hF);
            rd(bad[i], d, rv);
            checks++;
            if (rv !== 1'b1 || d !== 32'd0) begin
                failures++;
                $display("FAIL unmapped_%h: rvalid=%b data=%h, want 1 00000000", bad[i], rv, d);
            end
        end
        rd64(16'h4000, d64, rv);
        checks++;
        if (d64 !== m_cmp || msip !== m_msip) begin
            failures++;
            $display("FAIL unmapped_alias: cmp=%h msip=%b, want %h %b", d64, msip, m_cmp, m_msip);
        end
    endtask

    task automatic test_msip();
        logic [31:0] d;
        logic        rv;
        logic [31:0] wd;
        logic [3:0]  s;
        wr(16'h0000, 32'h1, 4'hF);
        checks++;
        if (msip !== 1'b1) begin
            failures++;
            $display("FAIL msip_set: msip=%b, want 1", msip);
        end
        rd(16'h0000, d, rv);
        checks++;
        if (rv !== 1'b1 || d !== 32'h1) begin
            failures++;
            $display("FAIL msip_read1: rvalid=%b data=%h, want 1 00000001", rv, d);
        end
        wr(16'h0000, 32'h0, 4'hF);
        checks++;
        if (msip !== 1'b0) begin
            failures++;
            $display("FAIL msip_clear: msip=%b, want 0", msip);
        end
        wr(16'h0000, 32'hFFFF_FFFF, 4'hF);
        rd(16'h0000, d, rv);
        checks++;
        if (rv !== 1'b1 || d !== 32'h0000_0001) begin
            failures++;
            $display("FAIL msip_allones: rvalid=%b data=%h, want 1 00000001", rv, d);
        end
        for (int i = 0; i < 8; i++) begin
            wd = $urandom;
            s  = 4'($urandom_range(1, 15));
            wr(16'($urandom_range(0, 3)), wd, s);
            rd(16'h0000, d, rv);
            checks++;
            if (msip !== m_msip || rv !== 1'b1 || d !== {31'd0, m_msip}) begin
                failures++;
                $display("FAIL msip_rand%0d: msip=%b rvalid=%b data=%h, want %b 1 %h",
                         i, msip, rv, d, m_msip, {31'd0, m_msip});
            end
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk_i);
        bus.iob_avalid = 1'b1;
        bus.iob_addr   = 16'h4000;
        bus.iob_wstrb  = 4'h0;
        @(negedge clk_i);
        bus.iob_addr = 16'h4004;
        checks++;
        if (bus.iob_rvalid !== 1'b1 || bus.iob_rdata !== m_cmp[31:0]) begin
            failures++;
            $display("FAIL b2b_first: rvalid=%b data=%h, want 1 %h", bus.iob_rvalid, bus.iob_rdata, m_cmp[31:0]);
        end
        @(negedge clk_i);
        bus.iob_avalid = 1'b0;
        checks++;
        if (bus.iob_rvalid !== 1'b1 || bus.iob_rdata !== m_cmp[63:32]) begin
            failures++;
            $display("FAIL b2b_second: rvalid=%b data=%h, want 1 %h", bus.iob_rvalid, bus.iob_rdata, m_cmp[63:32]);
        end
        @(negedge clk_i);
        checks++;
        if (bus.iob_rvalid !== 1'b0 || bus.iob_rdata !== m_cmp[63:32]) begin
            failures++;
            $display("FAIL b2b_hold: rvalid=%b data=%h, want 0 %h", bus.iob_rvalid, bus.iob_rdata, m_cmp[63:32]);
        end
    endtask

    task automatic test_timer();
        logic [63:0] base;
        int          k;
        wr(16'hBFF8, 32'd0, 4'hF);
        wr(16'hBFFC, 32'd0, 4'hF);
        wr(16'h4004, 32'd0, 4'hF);
        wr(16'h4000, 32'd10, 4'hF);
        for (int i = 1; i <= 10; i++) begin
            tick();
            checks++;
            if (mtip !== (m_mtime >= m_cmp)) begin
                failures++;
                $display("FAIL timer_tick%0d: mtip=%b, want %b", i, mtip, m_mtime >= m_cmp);
            end
        end
        wr(16'h4000, 32'd20, 4'hF);
        checks++;
        if (mtip !== 1'b1) begin
            failures++;
            $display("FAIL timer_drop_latency: mtip=%b, want 1", mtip);
        end
        @(negedge clk_i);
        checks++;
        if (mtip !== (m_mtime >= m_cmp)) begin
            failures++;
            $display("FAIL timer_drop: mtip=%b, want %b", mtip, m_mtime >= m_cmp);
        end
        for (int r = 0; r < 4; r++) begin
            base = {$urandom, $urandom};
            wr(16'hBFF8, base[31:0], 4'hF);
            wr(16'hBFFC, base[63:32], 4'hF);
            base = base + 64'($urandom_range(0, 4));
            wr(16'h4000, base[31:0], 4'hF);
            wr(16'h4004, base[63:32], 4'hF);
            @(negedge clk_i);
            checks++;
            if (mtip !== (m_mtime >= m_cmp)) begin
                failures++;
                $display("FAIL timer_rand%0d_start: mtip=%b, want %b", r, mtip, m_mtime >= m_cmp);
            end
            k = $urandom_range(1, 5);
            for (int t = 0; t < k; t++) begin
                tick();
                checks++;
                if (mtip !== (m_mtime >= m_cmp)) begin
                    failures++;
                    $display("FAIL timer_rand%0d_tick%0d: mtip=%b, want %b", r, t, mtip, m_mtime >= m_cmp);
                end
            end
        end
    endtask

    task automatic test_carry_wrap();
        logic [63:0] d64;
        logic        rv;
        wr(16'hBFF8, 32'hFFFF_FFFF, 4'hF);
        wr(16'hBFFC, 32'h0, 4'hF);
        tick();
        rd64(16'hBFF8, d64, rv);
        checks++;
        if (rv !== 1'b1 || d64 !== 64'h0000_0001_0000_0000 || d64 !== m_mtime) begin
            failures++;
            $display("FAIL carry: rvalid=%b data=%h, want 1 0000000100000000", rv, d64);
        end
        wr(16'hBFF8, 32'hFFFF_FFFF, 4'hF);
        wr(16'hBFFC, 32'hFFFF_FFFF, 4'hF);
        tick();
        rd64(16'hBFF8, d64, rv);
        checks++;
        if (rv !== 1'b1 || d64 !== 64'd0 || d64 !== m_mtime) begin
            failures++;
            $display("FAIL wrap: rvalid=%b data=%h, want 1 0000000000000000", rv, d64);
        end
    endtask

    task automatic test_collision();
        logic [63:0] d64;
        logic        rv;
        wr(16'hBFFC, 32'h0, 4'hF);
        wr(16'hBFF8, 32'($urandom_range(100, 200)), 4'hF);
        @(negedge clk_i);
        rt_clk = 1'b1;
        repeat (2) @(negedge clk_i);
        // This write is sampled on the same edge that consumes the tick.
        bus.iob_avalid = 1'b1;
        bus.iob_addr   = 16'hBFF8;
        bus.iob_wdata  = 32'd5;
        bus.iob_wstrb  = 4'hF;
        @(negedge clk_i);
        bus.iob_avalid = 1'b0;
        bus.iob_wstrb  = 4'h0;
        rt_clk         = 1'b0;
        m_mtime        = 64'd5;
        repeat (2) @(negedge clk_i);
        rd64(16'hBFF8, d64, rv);
        checks++;
        if (rv !== 1'b1 || d64 !== m_mtime) begin
            failures++;
            $display("FAIL collision_write_wins: rvalid=%b data=%h, want 1 %h", rv, d64, m_mtime);
        end
        tick();
        rd64(16'hBFF8, d64, rv);
        checks++;
        if (rv !== 1'b1 || d64 !== m_mtime) begin
            failures++;
            $display("FAIL collision_next_tick: rvalid=%b data=%h, want 1 %h", rv, d64, m_mtime);
        end
    endtask

    task automatic test_cke();
        logic [63:0] d64;
        logic [31:0] d;
        logic        rv;
        @(negedge clk_i);
        cke_i = 1'b0;
        bus_write(16'hBFF8, 32'hDEAD_BEEF, 4'hF);   // must be ignored
        @(negedge clk_i);
        rt_clk = 1'b1;
        repeat (3) @(negedge clk_i);
        rt_clk = 1'b0;
        repeat (3) @(negedge clk_i);
        rd(16'hBFF8, d, rv);
        checks++;
        if (rv !== 1'b0) begin
            failures++;
            $display("FAIL cke_no_rvalid: rvalid=%b, want 0", rv);
        end
        cke_i = 1'b1;
        rd64(16'hBFF8, d64, rv);
        checks++;
        if (rv !== 1'b1 || d64 !== m_mtime) begin
            failures++;
            $display("FAIL cke_frozen_mtime: rvalid=%b data=%h, want 1 %h", rv, d64, m_mtime);
        end
        @(negedge clk_i);
        bus.iob_avalid = 1'b1;
        bus.iob_addr   = 16'h4000;
        bus.iob_wstrb  = 4'h0;
        @(negedge clk_i);
        bus.iob_avalid = 1'b0;
        cke_i          = 1'b0;
        @(negedge clk_i);
        checks++;
        if (bus.iob_rvalid !== 1'b1 || bus.iob_rdata !== m_cmp[31:0]) begin
            failures++;
            $display("FAIL cke_hold_rvalid: rvalid=%b data=%h, want 1 %h", bus.iob_rvalid, bus.iob_rdata, m_cmp[31:0]);
        end
        cke_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (bus.iob_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL cke_release_rvalid: rvalid=%b, want 0", bus.iob_rvalid);
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] d64;
        logic [31:0] d;
        logic        rv;
        wr(16'h0000, 32'h1, 4'hF);
        wr(16'hBFFC, 32'h0, 4'hF);
        wr(16'hBFF8, 32'd100, 4'hF);
        wr(16'h4004, 32'h0, 4'hF);
        wr(16'h4000, 32'd50, 4'hF);
        @(negedge clk_i);
        checks++;
        if (mtip !== 1'b1 || msip !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset: mtip=%b msip=%b, want 1 1", mtip, msip);
        end
        bus.iob_avalid = 1'b1;
        bus.iob_addr   = 16'hBFF8;
        bus.iob_wstrb  = 4'h0;
        rt_clk         = 1'b1;
        @(negedge clk_i);
        bus.iob_avalid = 1'b0;
        arst_i         = 1'b1;
        @(negedge clk_i);
        rt_clk = 1'b0;
        checks++;
        if (bus.iob_rvalid !== 1'b0 || bus.iob_rdata !== 32'd0 || mtip !== 1'b0 || msip !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: rvalid=%b rdata=%h mtip=%b msip=%b, want 0 00000000 0 0",
                     bus.iob_rvalid, bus.iob_rdata, mtip, msip);
        end
        @(negedge clk_i);
        arst_i = 1'b0;
        model_reset();
        repeat (4) @(negedge clk_i);
        rd64(16'hBFF8, d64, rv);
        checks++;
        if (rv !== 1'b1 || d64 !== m_mtime) begin
            failures++;
            $display("FAIL mid_reset_mtime: rvalid=%b data=%h, want 1 %h", rv, d64, m_mtime);
        end
        rd64(16'h4000, d64, rv);
        rd(16'h0000, d, rv);
        checks++;
        if (d64 !== m_cmp || d !== 32'd0 || bus.iob_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset_regs: cmp=%h msip=%h ready=%b, want %h 00000000 1",
                     d64, d, bus.iob_ready, m_cmp);
        end
    endtask

    // ---------------- sequence ----------------
    initial begin
        cke_i          = 1'b1;
        arst_i         = 1'b1;
        rt_clk         = 1'b0;
        bus.iob_avalid = 1'b0;
        bus.iob_addr   = '0;
        bus.iob_wdata  = '0;
        bus.iob_wstrb  = '0;
        model_reset();

        test_reset();
        test_strobes_unmapped();
        test_msip();
        test_back_to_back();
        test_timer();
        test_carry_wrap();
        test_collision();
        test_cke();
        test_reset_mid();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
